// File: rtl/game_pkg.sv
// Shared FSM state encoding and default game tuning for the game controller.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DYING     = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam int DEF_START_LIVES  = 3;
    localparam int DEF_DEATH_FRAMES = 60;
    localparam int DEF_WIN_FRAMES   = 30;
    localparam int DEF_MAX_LEVEL    = 9;

endpackage

// File: rtl/frame_timer.sv
// Counts frame ticks up to a load value; o_done is combinational on the final tick.
// Latency: done asserts in the cycle of the load-th tick; clear wins over tick; no backpressure.
module frame_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_tick,
    input  logic [7:0] i_load,
    output logic       o_done,
    output logic [7:0] o_count
);

    logic [7:0] r_cnt;
    logic       w_last;

    assign w_last  = (r_cnt == (i_load - 8'd1));
    assign o_done  = i_tick && !i_clear && w_last;
    assign o_count = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_clear || o_done) begin
            r_cnt <= 8'd0;
        end else if (i_tick) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/game_controller.sv
// Game FSM: lives, score, level and frog control; all outputs registered, 1-cycle latency
// from collision/start inputs; no backpressure, collisions are sampled every cycle in PLAY.
module game_controller
    import game_pkg::*;
#(
    parameter int START_LIVES  = DEF_START_LIVES,
    parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
    parameter int WIN_FRAMES   = DEF_WIN_FRAMES,
    parameter int MAX_LEVEL    = DEF_MAX_LEVEL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        start_btn,
    input  logic        death_collision,
    input  logic        win_collision,
    output logic [3:0]  current_level,
    output logic [2:0]  lives,
    output logic [15:0] score,
    output logic        frog_reset,
    output logic        freeze,
    output logic        game_over,
    output logic [2:0]  state
);

    localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);
    localparam logic [3:0] LEVEL_MAX  = 4'(MAX_LEVEL);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_level, w_level_nxt;
    logic [2:0]  r_lives, w_lives_nxt;
    logic [15:0] r_score, w_score_nxt;
    logic        r_frog_reset;
    logic        r_freeze;
    logic        r_game_over;
    logic        r_start_q;

    logic        w_start_edge;
    logic        w_hold;
    logic        w_timer_done;
    logic [7:0]  w_timer_load;
    logic [7:0]  w_timer_count;
    logic [16:0] w_score_sum;

    assign w_start_edge = start_btn && !r_start_q;
    assign w_hold       = (r_state == ST_DYING) || (r_state == ST_LEVEL_UP);
    assign w_timer_load = (r_state == ST_DYING) ? 8'(DEATH_FRAMES) : 8'(WIN_FRAMES);
    assign w_score_sum  = {1'b0, r_score} + {13'd0, r_level};

    // Held clear outside the hold states, so every entry starts from zero.
    frame_timer u_frame_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (!w_hold),
        .i_tick  (frame_tick && w_hold),
        .i_load  (w_timer_load),
        .o_done  (w_timer_done),
        .o_count (w_timer_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_level      <= 4'd0;
            r_lives      <= LIVES_INIT;
            r_score      <= 16'd0;
            r_frog_reset <= 1'b0;
            r_freeze     <= 1'b1;
            r_game_over  <= 1'b0;
            r_start_q    <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_level      <= w_level_nxt;
            r_lives      <= w_lives_nxt;
            r_score      <= w_score_nxt;
            r_frog_reset <= (w_state_nxt == ST_PLAY) && (r_state != ST_PLAY);
            r_freeze     <= (w_state_nxt != ST_PLAY);
            r_game_over  <= (w_state_nxt == ST_GAME_OVER);
            r_start_q    <= start_btn;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_lives_nxt = r_lives;
        w_score_nxt = r_score;
        unique case (r_state)
            ST_IDLE: begin
                w_level_nxt = 4'd0;
                w_lives_nxt = LIVES_INIT;
                w_score_nxt = 16'd0;
                if (w_start_edge) begin
                    w_state_nxt = ST_PLAY;
                    w_level_nxt = 4'd1;
                end
            end
            ST_PLAY: begin
                // Death outranks a simultaneous win and scores nothing.
                if (death_collision) begin
                    w_state_nxt = ST_DYING;
                    w_lives_nxt = (r_lives == 3'd0) ? 3'd0 : r_lives - 3'd1;
                end else if (win_collision) begin
                    w_state_nxt = ST_LEVEL_UP;
                    w_score_nxt = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
                end
            end
            ST_DYING: begin
                if (w_timer_done) begin
                    w_state_nxt = (r_lives == 3'd0) ? ST_GAME_OVER : ST_PLAY;
                end
            end
            ST_LEVEL_UP: begin
                if (w_timer_done) begin
                    w_state_nxt = ST_PLAY;
                    w_level_nxt = (r_level >= LEVEL_MAX) ? LEVEL_MAX : r_level + 4'd1;
                end
            end
            ST_GAME_OVER: begin
                if (w_start_edge) begin
                    w_state_nxt = ST_PLAY;
                    w_level_nxt = 4'd1;
                    w_lives_nxt = LIVES_INIT;
                    w_score_nxt = 16'd0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign current_level = r_level;
    assign lives         = r_lives;
    assign score         = r_score;
    assign frog_reset    = r_frog_reset;
    assign freeze        = r_freeze;
    assign game_over     = r_game_over;
    assign state         = r_state;

endmodule
